writeback_buffer: RTL and testbench
===================================

# writeback_buffer

Line-granular write buffer between the dcache refill/evict port and the memory arbiter's dcache-side port. Absorbs dirty-line evictions into a small FIFO so the dcache never waits on memory for a write. Drains the FIFO to memory in the background. Serves reads from buffered lines, so memory is never read stale.

## Interface
- ADDR_SIZE, 32, byte address width
- LINE_SIZE, 256, line width in bits; offset bits = log2(LINE_SIZE/8)
- DEPTH, 4, buffer entries (power of two, ≥2)
- clk_i  in  1  clock; the only clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  cache request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_write_i  in  1  1 = line write (eviction), 0 = line read (refill)
- req_addr_i  in  ADDR_SIZE  line address; offset bits ignored
- req_wdata_i  in  LINE_SIZE  write line data
- resp_valid_o  out  1  one-cycle pulse: write ack or read data valid
- resp_rdata_o  out  LINE_SIZE  read line data, valid with resp_valid_o
- mem_req_valid_o  out  1  memory request valid, held until ready
- mem_req_ready_i  in  1  memory accepted request
- mem_req_write_o  out  1  memory request type
- mem_req_addr_o  out  ADDR_SIZE  line-aligned address (offset bits zero)
- mem_req_wdata_o  out  LINE_SIZE  drain data
- mem_resp_valid_i  in  1  memory completion: write ack or read data
- mem_resp_rdata_i  in  LINE_SIZE  memory read data

## Operation
- Entry: valid, line address (ADDR_SIZE minus offset bits), line data. Head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- req_ready_o = (count != DEPTH) && no read miss pending. Depends on no input in the same cycle.
- Accepted write, no matching valid entry → allocate at tail.
- Accepted write, matching entry that is not the head in DRAIN → overwrite that entry's data (coalesce); count unchanged.
- Accepted write, only match is the head in DRAIN → allocate a new entry.
- Accepted read: compare against all valid entries. On hit, return the youngest match's data. On miss, set read pending and request memory.
- Memory FSM (one outstanding memory transaction):
  - IDLE: read pending → RD_REQ; else count>0 → WR_REQ.
  - WR_REQ: drive head; on mem_req_ready_i → WR_WAIT.
  - WR_WAIT: on mem_resp_valid_i pop head → IDLE.
  - RD_REQ: on ready → RD_WAIT.
  - RD_WAIT: on mem_resp_valid_i return data, clear pending → IDLE.
- Read miss takes priority over draining. Ordering is safe because a miss proves no buffered copy exists.
- Pop and upstream allocate in the same cycle: both take effect, count unchanged. Pop and a read hit on the head in the same cycle: the hit returns the head's data.

## Timing
- Write: resp_valid_o pulse the cycle after acceptance.
- Read hit: resp_valid_o + data the cycle after acceptance; no memory traffic.
- Read miss: mem_req_valid_o asserts the cycle after acceptance if IDLE, else the cycle after the current drain returns to IDLE. resp_valid_o asserts the cycle after mem_resp_valid_i.
- mem_req_* are stable while mem_req_valid_o && !mem_req_ready_i.
- Reset values: all outputs 0, count 0, pointers 0, FSM IDLE, no pending read. Reset mid-transaction discards buffered and in-flight data; the memory side shares reset_i.

## Structure
- Package definitions: wb_state_t enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT).
- One sub-module, writeback_fifo: storage, pointers, count, parallel lookup (hit, youngest index), coalesce write port.
- Top FSM and handshakes stay in writeback_buffer.

## Test plan
- Write 0x100 with data A, memory ready stalled → resp_valid next cycle; count 1. Release memory → one write to 0x100 with A.
- Write 0x100=A, write 0x104=B (same line) before drain → count 1; memory later sees a single write to 0x100 with B.
- Fill DEPTH=4 lines 0x000/0x020/0x040/0x060 with memory stalled → req_ready_o low. Release → drains in order 0x000..0x060.
- Buffer 0x200=C, then read 0x200 → resp_rdata C one cycle later; no mem_req_valid_o with write=0.
- Drain of 0x000 in WR_WAIT, read miss to 0x400 → read issues after drain ack, before the next queued drain; data returned the cycle after mem_resp_valid_i.
- Assert reset_i while in RD_WAIT with count 2 → outputs 0 immediately; after release count 0 and req_ready_o 1.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// Types shared by the dcache write-back buffer and its storage sub-module.
package writeback_buffer_pkg;

  // Memory-side sequencer: one outstanding memory transaction at a time.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } wb_state_t;

  // Number of byte-offset bits inside one line.
  function automatic int line_offset_bits(input int line_size);
    return $clog2(line_size / 8);
  endfunction

endpackage

// File: rtl/writeback_fifo.sv
// Line storage for the write-back buffer: circular FIFO with a parallel
// line-address lookup that reports the youngest matching entry.
module writeback_fifo
  import writeback_buffer_pkg::*;
#(
  parameter int TAG_W = 27,
  parameter int LINE_SIZE = 256,
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 coalesce,
  input  logic                 pop,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]     coalesce_idx,
  input  logic [TAG_W-1:0]     lookup_tag,
  input  logic                 lookup_skip_head,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [LINE_SIZE-1:0] hit_data,
  output logic [TAG_W-1:0]     head_tag,
  output logic [LINE_SIZE-1:0] head_data,
  output logic [CNT_W-1:0]     count
);

  logic [TAG_W-1:0]     tag_q  [DEPTH];
  logic [LINE_SIZE-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [IDX_W-1:0]     scan_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + IDX_W'(1);
      if (pop)  head <= head + IDX_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: occupancy is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= wr_tag;
      data_q[tail] <= wr_data;
    end else if (coalesce) begin
      data_q[coalesce_idx] <= wr_data;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest copy.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + IDX_W'(i);
      if ((CNT_W'(i) < count) && (tag_q[scan_idx] == lookup_tag) &&
          !(lookup_skip_head && (i == 0))) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign hit_data  = data_q[hit_idx];
  assign head_tag  = tag_q[head];
  assign head_data = data_q[head];

endmodule

// File: rtl/writeback_buffer.sv
// Dcache-side write-back buffer: absorbs line evictions, drains them to
// memory in the background and serves refills from buffered lines.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 256,
  parameter int DEPTH = 4,
  localparam int OFF_W = line_offset_bits(LINE_SIZE),
  localparam int TAG_W = ADDR_SIZE - OFF_W,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [LINE_SIZE-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  output logic [LINE_SIZE-1:0] resp_rdata_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_write_o,
  output logic [ADDR_SIZE-1:0] mem_req_addr_o,
  output logic [LINE_SIZE-1:0] mem_req_wdata_o,
  input  logic                 mem_resp_valid_i,
  input  logic [LINE_SIZE-1:0] mem_resp_rdata_i,
  output wb_state_t            dbg_state_o,
  output logic [CNT_W-1:0]     dbg_count_o
);

  // Handshakes: a request transfers on the clock edge where valid && ready
  // are both high; a valid request holds all of its fields stable until that
  // edge, and ready never depends on valid in the same cycle.

  wb_state_t            state;
  wb_state_t            state_next;
  logic                 out_of_reset;
  logic                 rd_pending;
  logic [TAG_W-1:0]     rd_tag;
  logic [TAG_W-1:0]     req_tag;
  logic                 accept;
  logic                 draining;
  logic                 rd_hit;
  logic                 rd_miss;
  logic                 wr_push;
  logic                 wr_coalesce;
  logic                 pop;
  logic                 rd_done;
  logic                 fifo_hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [LINE_SIZE-1:0] hit_data;
  logic [TAG_W-1:0]     head_tag;
  logic [LINE_SIZE-1:0] head_data;
  logic [CNT_W-1:0]     count;
  logic                 unused_offset;

  assign req_tag       = req_addr_i[ADDR_SIZE-1:OFF_W];
  assign unused_offset = ^req_addr_i[OFF_W-1:0];

  // Held low while reset is asserted so every output reads 0 in reset.
  assign req_ready_o = out_of_reset && (count != CNT_W'(DEPTH)) && !rd_pending;
  assign accept      = req_valid_i && req_ready_o;

  // Head being drained is frozen: its data is already on (or past) the bus.
  assign draining    = (state == WR_REQ) || (state == WR_WAIT);
  assign wr_push     = accept && req_write_i && !fifo_hit;
  assign wr_coalesce = accept && req_write_i && fifo_hit;
  assign rd_hit      = accept && !req_write_i && fifo_hit;
  assign rd_miss     = accept && !req_write_i && !fifo_hit;
  assign pop         = (state == WR_WAIT) && mem_resp_valid_i;
  assign rd_done     = (state == RD_WAIT) && mem_resp_valid_i;

  writeback_fifo #(
    .TAG_W    (TAG_W),
    .LINE_SIZE(LINE_SIZE),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk             (clk_i),
    .rst             (reset_i),
    .push            (wr_push),
    .coalesce        (wr_coalesce),
    .pop             (pop),
    .wr_tag          (req_tag),
    .wr_data         (req_wdata_i),
    .coalesce_idx    (hit_idx),
    .lookup_tag      (req_tag),
    .lookup_skip_head(req_write_i && draining),
    .hit             (fifo_hit),
    .hit_idx         (hit_idx),
    .hit_data        (hit_data),
    .head_tag        (head_tag),
    .head_data       (head_data),
    .count           (count)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // A read miss outranks draining; the miss proves memory holds the only copy.
  always_comb begin
    state_next      = state;
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    case (state)
      IDLE: begin
        if (rd_pending || rd_miss)     state_next = RD_REQ;
        else if (count != CNT_W'(0))   state_next = WR_REQ;
      end
      WR_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_req_addr_o  = {head_tag, {OFF_W{1'b0}}};
        mem_req_wdata_o = head_data;
        if (mem_req_ready_i) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_resp_valid_i) state_next = IDLE;
      end
      RD_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {rd_tag, {OFF_W{1'b0}}};
        if (mem_req_ready_i) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_resp_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_of_reset <= 1'b0;
      rd_pending   <= 1'b0;
      rd_tag       <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      out_of_reset <= 1'b1;
      if (rd_miss) begin
        rd_pending <= 1'b1;
        rd_tag     <= req_tag;
      end else if (rd_done) begin
        rd_pending <= 1'b0;
      end
      resp_valid_o <= (accept && req_write_i) || rd_hit || rd_done;
      if (rd_hit)       resp_rdata_o <= hit_data;
      else if (rd_done) resp_rdata_o <= mem_resp_rdata_i;
    end
  end

  assign dbg_state_o = state;
  assign dbg_count_o = count;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: upstream responses and memory requests
// are each checked against expectation queues filled by the stimulus.
module tb_writeback_buffer;
  import writeback_buffer_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [LW-1:0] DATA_A  = {8{32'hA0A0_0001}};
  localparam logic [LW-1:0] DATA_B  = {8{32'hB0B0_0002}};
  localparam logic [LW-1:0] DATA_C  = {8{32'hC0C0_0003}};
  localparam logic [LW-1:0] DATA_D0 = {8{32'hD000_0010}};
  localparam logic [LW-1:0] DATA_D1 = {8{32'hD111_0011}};
  localparam logic [LW-1:0] DATA_D2 = {8{32'hD222_0012}};
  localparam logic [LW-1:0] DATA_D3 = {8{32'hD333_0013}};
  localparam logic [LW-1:0] RD_400  = {8{32'h0000_0400}};
  localparam logic [LW-1:0] RD_800  = {8{32'h0000_0800}};

  typedef struct {
    logic          is_read;
    logic [LW-1:0] data;
    int            due;
  } resp_exp_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } mem_exp_t;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [LW-1:0] req_wdata_i;
  logic          resp_valid_o;
  logic [LW-1:0] resp_rdata_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic          mem_req_write_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [LW-1:0] mem_req_wdata_o;
  logic          mem_resp_valid_i;
  logic [LW-1:0] mem_resp_rdata_i;
  wb_state_t     dbg_state_o;
  logic [2:0]    dbg_count_o;

  resp_exp_t exp_q[$];
  mem_exp_t  exp_mem_q[$];
  resp_exp_t mon_e;
  mem_exp_t  mem_e;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rd_resp_cyc = 0;
  int mem_lat     = 2;
  bit mem_stall   = 1'b1;
  bit mem_busy    = 1'b0;

  writeback_buffer #(.ADDR_SIZE(AW), .LINE_SIZE(LW), .DEPTH(4)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_write_i     (req_write_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_write_o (mem_req_write_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_rdata_i(mem_resp_rdata_i),
    .dbg_state_o     (dbg_state_o),
    .dbg_count_o     (dbg_count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- memory model + memory-side monitor ----------------
  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {8{a}};
  endfunction

  initial begin : mem_model
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    forever begin
      @(negedge clk_i);
      if (!reset_i && mem_req_valid_o && mem_req_ready_i) begin
        mem_busy  = 1'b1;
        cur_write = mem_req_write_o;
        cur_addr  = mem_req_addr_o;
        if (exp_mem_q.size() == 0) begin
          timeout_fail("mem_req_unexpected");
          $display("FAIL mem_req_unexpected: write %0b addr %h", cur_write, cur_addr);
        end else begin
          mem_e = exp_mem_q.pop_front();
          check("mem_write", cur_write, mem_e.write);
          check("mem_addr", cur_addr, mem_e.addr);
          if (mem_e.write) check("mem_wdata", mem_req_wdata_o, mem_e.data);
        end
        @(posedge clk_i); #1;
        mem_req_ready_i = 1'b0;
        repeat (mem_lat) @(posedge clk_i);
        #1;
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = cur_write ? '0 : mem_line(cur_addr);
        if (!cur_write) rd_resp_cyc = cyc;
        @(posedge clk_i); #1;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;
        mem_req_ready_i  = !mem_stall;
        mem_busy         = 1'b0;
      end
    end
  end

  // ---------------- upstream response scoreboard ----------------
  always @(negedge clk_i) begin
    if (!reset_i && resp_valid_o) begin
      if (exp_q.size() == 0) begin
        timeout_fail("resp_unexpected");
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_cycle", cyc, (mon_e.due >= 0) ? mon_e.due : rd_resp_cyc + 1);
        if (mon_e.is_read) check("resp_rdata", resp_rdata_o, mon_e.data);
      end
    end
  end

  // ---------------- driver tasks (call at posedge + #1) ----------------
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                      input logic [LW-1:0] exp_rdata, input logic miss);
    bit ok = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = a;
    req_wdata_i = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back('{is_read: !wr, data: exp_rdata, due: miss ? -1 : cyc + 1});
    else    timeout_fail("req_accept");
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
  endtask

  task automatic expect_mem(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_mem_q.push_back('{write: wr, addr: a, data: d});
  endtask

  task automatic set_stall(input bit s);
    mem_stall = s;
    if (!mem_busy) mem_req_ready_i = !s;
  endtask

  task automatic wait_state(input wb_state_t s, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (dbg_state_o == s) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail(name);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_drained(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (dbg_count_o == 3'd0 && dbg_state_o == IDLE && !mem_busy &&
          exp_q.size() == 0 && exp_mem_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeout_fail(name);
    @(posedge clk_i); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_i          = 1'b1;
    req_valid_i      = 1'b0;
    req_write_i      = 1'b0;
    req_addr_i       = '0;
    req_wdata_i      = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b0);
    check("rst_count", dbg_count_o, 3'd0);
    check("rst_state", dbg_state_o, IDLE);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("ready_after_reset", req_ready_o, 1'b1);

    // Single write, memory stalled, then released.
    send(1'b1, 32'h100, DATA_A, '0, 1'b0);
    check("t1_count", dbg_count_o, 3'd1);
    expect_mem(1'b1, 32'h100, DATA_A);
    set_stall(1'b0);
    wait_drained("t1_drain");

    // Two writes to the same line back-to-back coalesce into one entry.
    set_stall(1'b1);
    send(1'b1, 32'h100, DATA_A, '0, 1'b0);
    send(1'b1, 32'h104, DATA_B, '0, 1'b0);
    check("t2_count", dbg_count_o, 3'd1);
    expect_mem(1'b1, 32'h100, DATA_B);
    set_stall(1'b0);
    wait_drained("t2_drain");

    // Fill all four entries; buffer must stop accepting, then drain in order.
    set_stall(1'b1);
    send(1'b1, 32'h000, DATA_D0, '0, 1'b0);
    send(1'b1, 32'h020, DATA_D1, '0, 1'b0);
    send(1'b1, 32'h040, DATA_D2, '0, 1'b0);
    send(1'b1, 32'h060, DATA_D3, '0, 1'b0);
    check("t3_count_full", dbg_count_o, 3'd4);
    check("t3_ready_full", req_ready_o, 1'b0);
    expect_mem(1'b1, 32'h000, DATA_D0);
    expect_mem(1'b1, 32'h020, DATA_D1);
    expect_mem(1'b1, 32'h040, DATA_D2);
    expect_mem(1'b1, 32'h060, DATA_D3);
    set_stall(1'b0);
    wait_drained("t3_drain");

    // Read hit on a buffered line: data next cycle, no memory read.
    set_stall(1'b1);
    send(1'b1, 32'h200, DATA_C, '0, 1'b0);
    send(1'b0, 32'h200, '0, DATA_C, 1'b0);
    check("t4_count", dbg_count_o, 3'd1);
    expect_mem(1'b1, 32'h200, DATA_C);
    set_stall(1'b0);
    wait_drained("t4_drain");

    // Read miss during a drain goes ahead of the next queued drain.
    set_stall(1'b1);
    mem_lat = 4;
    send(1'b1, 32'h000, DATA_D0, '0, 1'b0);
    send(1'b1, 32'h020, DATA_D1, '0, 1'b0);
    expect_mem(1'b1, 32'h000, DATA_D0);
    expect_mem(1'b0, 32'h400, '0);
    expect_mem(1'b1, 32'h020, DATA_D1);
    set_stall(1'b0);
    wait_state(WR_WAIT, "t5_wr_wait");
    send(1'b0, 32'h400, '0, RD_400, 1'b1);
    check("t5_ready_pending", req_ready_o, 1'b0);
    wait_drained("t5_drain");

    // Read miss from IDLE requests memory the very next cycle.
    mem_lat = 2;
    expect_mem(1'b0, 32'h800, '0);
    send(1'b0, 32'h80C, '0, RD_800, 1'b1);
    check("t6_mem_valid_next", mem_req_valid_o, 1'b1);
    check("t6_mem_write_next", mem_req_write_o, 1'b0);
    wait_drained("t6_drain");

    // Reset while a read is outstanding with two lines still buffered.
    set_stall(1'b1);
    mem_lat = 8;
    send(1'b1, 32'h000, DATA_D0, '0, 1'b0);
    send(1'b1, 32'h020, DATA_D1, '0, 1'b0);
    send(1'b1, 32'h040, DATA_D2, '0, 1'b0);
    expect_mem(1'b1, 32'h000, DATA_D0);
    expect_mem(1'b0, 32'h600, '0);
    set_stall(1'b0);
    wait_state(WR_WAIT, "t7_wr_wait");
    send(1'b0, 32'h600, '0, '0, 1'b1);
    wait_state(RD_WAIT, "t7_rd_wait");
    check("t7_count_before_reset", dbg_count_o, 3'd2);
    reset_i = 1'b1;
    #1;
    check("t7_rst_resp_valid", resp_valid_o, 1'b0);
    check("t7_rst_mem_valid", mem_req_valid_o, 1'b0);
    check("t7_rst_mem_addr", mem_req_addr_o, 32'h0);
    check("t7_rst_req_ready", req_ready_o, 1'b0);
    check("t7_rst_count", dbg_count_o, 3'd0);
    exp_q.delete();
    exp_mem_q.delete();
    mem_stall = 1'b1;
    repeat (12) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("t7_ready_after", req_ready_o, 1'b1);
    check("t7_count_after", dbg_count_o, 3'd0);
    check("t7_state_after", dbg_state_o, IDLE);

    // Buffer still works normally after the mid-transaction reset.
    mem_lat = 2;
    send(1'b1, 32'h0E0, DATA_A, '0, 1'b0);
    check("t8_count", dbg_count_o, 3'd1);
    expect_mem(1'b1, 32'h0E0, DATA_A);
    set_stall(1'b0);
    wait_drained("t8_drain");

    check("final_resp_queue_empty", exp_q.size(), 0);
    check("final_mem_queue_empty", exp_mem_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
